// File: rtl/cluster_cg_pkg.sv
// Shared types and defaults for the cluster clock-gate controller.
// Imported by cluster_clock_gate_ctrl.
package cluster_cg_pkg;

    typedef enum logic [1:0] {
        CG_RUN   = 2'd0,
        CG_DRAIN = 2'd1,
        CG_GATED = 2'd2,
        CG_WAKE  = 2'd3
    } cg_state_e;

    localparam int DEF_IDLE_CYCLES = 4;
    localparam int DEF_WAKE_CYCLES = 2;

    // One counter is shared by DRAIN and WAKE, so it is sized for the longer of the two.
    function automatic int cnt_width(input int idle_cycles, input int wake_cycles);
        int longest;
        longest = (idle_cycles > wake_cycles) ? idle_cycles : wake_cycles;
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/cluster_clock_gate_ctrl.sv
// Cluster clock-gate enable sequencer driven by a 4-phase req/ack handshake.
// Runs on the ungated SoC clock; clk_en_o feeds the en_i of the gating cell.
module cluster_clock_gate_ctrl
    import cluster_cg_pkg::*;
#(
    parameter int IDLE_CYCLES = DEF_IDLE_CYCLES,
    parameter int WAKE_CYCLES = DEF_WAKE_CYCLES
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       gate_req_i,
    input  logic       busy_i,
    output logic       clk_en_o,
    output logic       gate_ack_o,
    output logic [1:0] state_o,
    output logic       err_o
);

    localparam int CNT_W = cnt_width(IDLE_CYCLES, WAKE_CYCLES);
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    cg_state_e        state_q, state_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic             clk_en_q, clk_en_n;
    logic             ack_q, ack_n;
    logic             err_q, err_n;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= CG_RUN;
            cnt_q    <= '0;
            clk_en_q <= 1'b1;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_n;
            cnt_q    <= cnt_n;
            clk_en_q <= clk_en_n;
            ack_q    <= ack_n;
            err_q    <= err_n;
        end
    end

    // Enable and ack are registered copies of what the next state implies.
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        err_n   = err_q;

        unique case (state_q)
            CG_RUN: begin
                if (gate_req_i) begin
                    state_n = CG_DRAIN;
                    cnt_n   = '0;
                end
            end
            CG_DRAIN: begin
                if (!gate_req_i) begin
                    state_n = CG_RUN;
                    cnt_n   = '0;
                end else if (busy_i) begin
                    cnt_n = '0;
                end else if (cnt_q == IDLE_LAST) begin
                    state_n = CG_GATED;
                end else begin
                    cnt_n = cnt_q + CNT_ONE;
                end
            end
            CG_GATED: begin
                if (busy_i) begin
                    err_n = 1'b1;
                end
                if (!gate_req_i) begin
                    state_n = CG_WAKE;
                    cnt_n   = '0;
                end
            end
            CG_WAKE: begin
                if (cnt_q == WAKE_LAST) begin
                    state_n = CG_RUN;
                end else begin
                    cnt_n = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_n = CG_RUN;
                cnt_n   = '0;
            end
        endcase

        clk_en_n = (state_n != CG_GATED);
        ack_n    = (state_n == CG_GATED) || (state_n == CG_WAKE);
    end

    assign clk_en_o   = clk_en_q;
    assign gate_ack_o = ack_q;
    assign state_o    = state_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_cluster_clock_gate_ctrl.sv
// Scoreboard bench for cluster_clock_gate_ctrl with the default 4/2 cycle settings.
// Stimulus pushes hand-computed expectations; a negedge monitor pops and compares.
module tb_cluster_clock_gate_ctrl;

    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_DRAIN = 2'd1;
    localparam logic [1:0] S_GATED = 2'd2;
    localparam logic [1:0] S_WAKE  = 2'd3;

    typedef struct {
        int         id;
        logic [1:0] st;
        logic       en;
        logic       ack;
        logic       err;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       gate_req;
    logic       busy;
    logic       clk_en;
    logic       gate_ack;
    logic [1:0] state;
    logic       err;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fails  = 0;
    int   step_id  = 0;
    logic exp_err  = 1'b0;

    cluster_clock_gate_ctrl #(
        .IDLE_CYCLES(4),
        .WAKE_CYCLES(2)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .gate_req_i (gate_req),
        .busy_i     (busy),
        .clk_en_o   (clk_en),
        .gate_ack_o (gate_ack),
        .state_o    (state),
        .err_o      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input int id, input logic [1:0] act,
                                input logic [1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fails++;
            $display("[TB] FAIL %s step %0d: got %0d, expected %0d", name, id, act, req);
        end
    endtask

    // One clock of stimulus; the expectation describes the outputs after this edge.
    task automatic apply_stimulus(input logic r, input logic b, input logic [1:0] st);
        exp_t e;
        @(negedge clk);
        gate_req = r;
        busy     = b;
        @(posedge clk);
        e.id  = step_id;
        e.st  = st;
        e.en  = (st != S_GATED);
        e.ack = (st == S_GATED) || (st == S_WAKE);
        e.err = exp_err;
        exp_q.push_back(e);
        step_id++;
    endtask

    task automatic gate_sequence();
        apply_stimulus(1'b1, 1'b0, S_DRAIN);
        apply_stimulus(1'b1, 1'b0, S_DRAIN);
        apply_stimulus(1'b1, 1'b0, S_DRAIN);
        apply_stimulus(1'b1, 1'b0, S_DRAIN);
        apply_stimulus(1'b1, 1'b0, S_GATED);
    endtask

    task automatic wake_sequence();
        apply_stimulus(1'b0, 1'b0, S_WAKE);
        apply_stimulus(1'b0, 1'b0, S_WAKE);
        apply_stimulus(1'b0, 1'b0, S_RUN);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_output("state_o", e.id, state, e.st);
                check_output("clk_en_o", e.id, {1'b0, clk_en}, {1'b0, e.en});
                check_output("gate_ack_o", e.id, {1'b0, gate_ack}, {1'b0, e.ack});
                check_output("err_o", e.id, {1'b0, err}, {1'b0, e.err});
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin : stimulus
        int drain_wait;
        rst      = 1'b1;
        gate_req = 1'b0;
        busy     = 1'b0;
        repeat (2) @(negedge clk);
        check_output("reset state_o", -1, state, S_RUN);
        check_output("reset clk_en_o", -1, {1'b0, clk_en}, 2'd1);
        check_output("reset gate_ack_o", -1, {1'b0, gate_ack}, 2'd0);
        check_output("reset err_o", -1, {1'b0, err}, 2'd0);
        rst = 1'b0;

        $display("[TB] idle after reset");
        repeat (4) apply_stimulus(1'b0, 1'b0, S_RUN);

        $display("[TB] plain gate then wake");
        gate_sequence();
        apply_stimulus(1'b1, 1'b0, S_GATED);
        wake_sequence();
        apply_stimulus(1'b0, 1'b0, S_RUN);

        $display("[TB] busy pulse restarts idle count");
        apply_stimulus(1'b1, 1'b0, S_DRAIN);
        apply_stimulus(1'b1, 1'b0, S_DRAIN);
        apply_stimulus(1'b1, 1'b1, S_DRAIN);
        apply_stimulus(1'b1, 1'b0, S_DRAIN);
        apply_stimulus(1'b1, 1'b0, S_DRAIN);
        apply_stimulus(1'b1, 1'b0, S_DRAIN);
        apply_stimulus(1'b1, 1'b0, S_GATED);
        wake_sequence();

        $display("[TB] abort during drain");
        apply_stimulus(1'b1, 1'b0, S_DRAIN);
        apply_stimulus(1'b1, 1'b0, S_DRAIN);
        apply_stimulus(1'b0, 1'b0, S_RUN);
        apply_stimulus(1'b0, 1'b0, S_RUN);
        apply_stimulus(1'b1, 1'b0, S_DRAIN);
        apply_stimulus(1'b0, 1'b1, S_RUN);
        apply_stimulus(1'b0, 1'b0, S_RUN);

        $display("[TB] request re-asserted during wake");
        gate_sequence();
        apply_stimulus(1'b0, 1'b0, S_WAKE);
        apply_stimulus(1'b1, 1'b0, S_WAKE);
        apply_stimulus(1'b1, 1'b0, S_RUN);
        apply_stimulus(1'b1, 1'b0, S_DRAIN);
        apply_stimulus(1'b0, 1'b0, S_RUN);

        $display("[TB] busy while gated sets sticky error");
        gate_sequence();
        exp_err = 1'b1;
        apply_stimulus(1'b1, 1'b1, S_GATED);
        apply_stimulus(1'b1, 1'b0, S_GATED);
        wake_sequence();
        apply_stimulus(1'b0, 1'b0, S_RUN);

        $display("[TB] async reset while gated");
        gate_sequence();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_output("async rst clk_en_o", -2, {1'b0, clk_en}, 2'd1);
        check_output("async rst gate_ack_o", -2, {1'b0, gate_ack}, 2'd0);
        check_output("async rst state_o", -2, state, S_RUN);
        check_output("async rst err_o", -2, {1'b0, err}, 2'd0);
        exp_err  = 1'b0;
        gate_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        apply_stimulus(1'b0, 1'b0, S_RUN);
        apply_stimulus(1'b0, 1'b0, S_RUN);

        drain_wait = 0;
        while (exp_q.size() > 0 && drain_wait < 10) begin
            @(negedge clk);
            drain_wait++;
        end
        @(posedge clk);
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fails++;
            $display("[TB] FAIL scoreboard drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
